// File: rtl/pic_priority_resolver_pkg.sv
// Shared constants, FSM state type and priority-rank helper for the PIC priority resolver.
package pic_pkg;
    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;
    localparam logic [IDX_W-1:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } pic_state_e;

    // Rank 0 is the highest priority; the level just above lp ranks first.
    function automatic logic [IDX_W-1:0] prio_rank(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] lp);
        return idx - lp - 3'd1;
    endfunction
endpackage

// File: rtl/pic_priority_resolver_if.sv
// Request/mask/EOI/INTA bundle between the PIC control logic and the priority resolver.
// Adds rotate_on_eoi when PIC_ROTATE_PRIORITY_EN is defined.
interface pic_priority_resolver_if
    import pic_pkg::*;
#(
    parameter int VEC_BASE_W = 5
);
    logic [NUM_IRQ-1:0]    irr;
    logic [NUM_IRQ-1:0]    imr;
    logic [VEC_BASE_W-1:0] vec_base;
    logic                  auto_eoi;
    logic                  eoi_cmd;
    logic                  eoi_specific;
    logic [IDX_W-1:0]      eoi_level;
    logic                  inta_n;
`ifdef PIC_ROTATE_PRIORITY_EN
    logic                  rotate_on_eoi;
`endif
    logic                  int_out;
    logic [NUM_IRQ-1:0]    data_out;
    logic                  data_oe;
    logic [NUM_IRQ-1:0]    isr;
    logic [NUM_IRQ-1:0]    irr_clear;

    modport master (
`ifdef PIC_ROTATE_PRIORITY_EN
        output rotate_on_eoi,
`endif
        output irr, imr, vec_base, auto_eoi, eoi_cmd, eoi_specific, eoi_level, inta_n,
        input  int_out, data_out, data_oe, isr, irr_clear
    );

    modport slave (
`ifdef PIC_ROTATE_PRIORITY_EN
        input  rotate_on_eoi,
`endif
        input  irr, imr, vec_base, auto_eoi, eoi_cmd, eoi_specific, eoi_level, inta_n,
        output int_out, data_out, data_oe, isr, irr_clear
    );
endinterface

// File: rtl/pic_prio_encoder.sv
// Rotating priority encoder: reports the first set bit starting at (base+1) mod 8 and wrapping.
module pic_prio_encoder
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [IDX_W-1:0]   base,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    logic [IDX_W-1:0] cand;

    // Scan lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            cand = base + IDX_W'(i) + 3'd1;
            if (vec[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/pic_priority_resolver.sv
// PIC priority resolver: picks the winning request, runs the two-pulse INTA sequence and tracks the ISR.
// Rotating priority (rotate_on_eoi input) is built only when PIC_ROTATE_PRIORITY_EN is defined.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ    = 8,
    parameter int VEC_BASE_W = 5
) (
    input logic                    clk,
    input logic                    reset,
    pic_priority_resolver_if.slave bus
);
    pic_state_e            state_q, state_d;
    logic                  inta_prev_q, inta_prev_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic                  spur_q, spur_d;
    logic [NUM_IRQ-1:0]    isr_q, isr_d;
    logic                  int_out_q, int_out_d;
    logic [NUM_IRQ-1:0]    data_out_q, data_out_d;
    logic                  data_oe_q, data_oe_d;
    logic [NUM_IRQ-1:0]    irr_clear_q, irr_clear_d;
    logic [IDX_W-1:0]      lp;
    logic [NUM_IRQ-1:0]    pending;
    logic [VEC_BASE_W-1:0] vec_base;
    logic                  win_vld, cur_vld, win_higher, fall, rise;
    logic [IDX_W-1:0]      win, cur;

`ifdef PIC_ROTATE_PRIORITY_EN
    logic [IDX_W-1:0]      lp_q, lp_d;
    assign lp = lp_q;
`else
    logic [IDX_W-1:0]      lp_d;
    assign lp = IDX_W'(NUM_IRQ - 1);
`endif

    assign pending    = bus.irr & ~bus.imr;
    assign vec_base   = bus.vec_base;
    assign fall       = inta_prev_q & ~bus.inta_n;
    assign rise       = ~inta_prev_q & bus.inta_n;
    assign win_higher = prio_rank(win, lp) < prio_rank(cur, lp);

    pic_prio_encoder u_win_enc (.vec(pending), .base(lp), .valid(win_vld), .idx(win));
    pic_prio_encoder u_cur_enc (.vec(isr_q),   .base(lp), .valid(cur_vld), .idx(cur));

    always_comb begin
        state_d     = state_q;
        inta_prev_d = bus.inta_n;
        sel_d       = sel_q;
        spur_d      = spur_q;
        isr_d       = isr_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        irr_clear_d = '0;
        lp_d        = lp;

        // EOI clears land before any ISR set below, so a same-cycle set survives.
        if (bus.eoi_cmd) begin
            if (bus.eoi_specific) begin
                isr_d[bus.eoi_level] = 1'b0;
            end else if (cur_vld) begin
                isr_d[cur] = 1'b0;
`ifdef PIC_ROTATE_PRIORITY_EN
                if (bus.rotate_on_eoi) lp_d = cur;
`endif
            end
        end

        case (state_q)
            IDLE: if (fall) begin
                state_d = ACK1;
                if (int_out_q && win_vld) begin
                    sel_d              = win;
                    spur_d             = 1'b0;
                    isr_d[win]         = 1'b1;
                    irr_clear_d[win]   = 1'b1;
                end else begin
                    sel_d  = SPURIOUS_LEVEL;
                    spur_d = 1'b1;
                end
            end
            ACK1: if (rise) state_d = WAIT2;
            WAIT2: if (fall) begin
                state_d    = ACK2;
                data_out_d = {vec_base, sel_q};
                data_oe_d  = 1'b1;
            end
            ACK2: if (rise) begin
                state_d   = IDLE;
                data_oe_d = 1'b0;
                if (bus.auto_eoi && !spur_q) begin
                    isr_d[sel_q] = 1'b0;
`ifdef PIC_ROTATE_PRIORITY_EN
                    if (bus.rotate_on_eoi) lp_d = sel_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Gated on the next state so the request drops in the same edge that starts an acknowledge.
        int_out_d = (state_d == IDLE) && win_vld && (!cur_vld || win_higher);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            sel_q       <= '0;
            spur_q      <= 1'b0;
            isr_q       <= '0;
            int_out_q   <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            irr_clear_q <= '0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= inta_prev_d;
            sel_q       <= sel_d;
            spur_q      <= spur_d;
            isr_q       <= isr_d;
            int_out_q   <= int_out_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            irr_clear_q <= irr_clear_d;
        end
    end

`ifdef PIC_ROTATE_PRIORITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lp_q <= IDX_W'(NUM_IRQ - 1);
        else        lp_q <= lp_d;
    end
`endif

    assign bus.int_out   = int_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;
    assign bus.isr       = isr_q;
    assign bus.irr_clear = irr_clear_q;
endmodule
